// File: rtl/qsys_blink_pio.sv
// Memory-mapped LED/lamp PIO with set/clear access and a shared blink phase.
// Each output bit can be gated off during the odd half of a programmable blink period.
module qsys_blink_pio #(
   parameter int DATA_WIDTH   = 18,
   parameter int PERIOD_WIDTH = 24,
   parameter int RESET_VALUE  = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] out_port
);

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_BLINK    = 3'd1;
   localparam logic [2:0] ADDR_PERIOD   = 3'd2;
   localparam logic [2:0] ADDR_STATUS   = 3'd3;
   localparam logic [2:0] ADDR_OUTSET   = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [DATA_WIDTH-1:0]   blink_q, blink_d;
   logic [PERIOD_WIDTH-1:0] period_q, period_d;
   logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
   logic                    phase_q, phase_d;
   logic [31:0]             readdata_q, readdata_d;

   logic                    wr_en;
   logic                    period_wr;
   logic [DATA_WIDTH-1:0]   wdata_field;
   logic                    unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   assign period_wr    = wr_en && (address == ADDR_PERIOD);
   assign wdata_field  = writedata[DATA_WIDTH-1:0];
   assign unused_wdata = ^writedata[31:DATA_WIDTH];

   always_comb begin
      data_d   = data_q;
      blink_d  = blink_q;
      period_d = period_q;
      if (wr_en) begin
         case (address)
            ADDR_DATA:     data_d   = wdata_field;
            ADDR_BLINK:    blink_d  = wdata_field;
            ADDR_PERIOD:   period_d = writedata[PERIOD_WIDTH-1:0];
            ADDR_OUTSET:   data_d   = data_q | wdata_field;
            ADDR_OUTCLEAR: data_d   = data_q & ~wdata_field;
            default:       ;
         endcase
      end
   end

   // A PERIOD write restarts the blink cleanly and wins over a terminal count.
   // The >= compare makes a shrinking PERIOD wrap at once instead of rolling over.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (period_wr || (period_q == '0)) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (cnt_q >= (period_q - PERIOD_WIDTH'(1))) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d   = cnt_q + PERIOD_WIDTH'(1);
      end
   end

   always_comb begin
      readdata_d = '0;
      case (address)
         ADDR_DATA:   readdata_d = 32'(data_q);
         ADDR_BLINK:  readdata_d = 32'(blink_q);
         ADDR_PERIOD: readdata_d = 32'(period_q);
         ADDR_STATUS: readdata_d = {31'b0, phase_q};
         default:     readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q     <= DATA_WIDTH'(RESET_VALUE);
         blink_q    <= '0;
         period_q   <= '0;
         cnt_q      <= '0;
         phase_q    <= 1'b0;
         readdata_q <= '0;
      end else begin
         data_q     <= data_d;
         blink_q    <= blink_d;
         period_q   <= period_d;
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign out_port = data_q & ~(blink_q & {DATA_WIDTH{phase_q}});

endmodule

// File: tb/tb_qsys_blink_pio.sv
// Directed bench for qsys_blink_pio: stimulus pushes expected values with a due cycle,
// a monitor pops and compares them against out_port / readdata.
module tb_qsys_blink_pio;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [17:0] out_port;

  qsys_blink_pio #(
    .DATA_WIDTH(18),
    .PERIOD_WIDTH(24),
    .RESET_VALUE(0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: kind 0 = out_port, kind 1 = readdata
  logic [31:0] exp_q[$];
  int          due_q[$];
  bit          kind_q[$];
  string       name_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input bit kind, input logic [31:0] exp, input int due, input string name);
    exp_q.push_back(exp);
    due_q.push_back(due);
    kind_q.push_back(kind);
    name_q.push_back(name);
  endtask

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      #1;
      while (exp_q.size() > 0 && due_q[0] <= cyc) begin
        logic [31:0] e;
        bit          k;
        string       nm;
        e  = exp_q.pop_front();
        k  = kind_q.pop_front();
        nm = name_q.pop_front();
        void'(due_q.pop_front());
        if (k) check(nm, readdata, e);
        else   check(nm, 32'(out_port), e);
      end
    end
  end

  // driver tasks (all called at a falling edge)
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string name);
    address = a;
    push_exp(1'b1, exp, cyc + 1, name);
    @(negedge clk);
  endtask

  task automatic expect_out(input logic [31:0] exp, input string name);
    push_exp(1'b0, exp, cyc, name);
  endtask

  // Watch STATUS and out_port for n cycles; DATA=3, BLINK=1 so bit0 follows the phase.
  task automatic watch_blink(input int n, input int half);
    bit ph;
    address = 3'd3;
    for (int i = 0; i < n; i++) begin
      ph = (half == 0) ? 1'b0 : bit'((i / half) % 2);
      expect_out(ph ? 32'h2 : 32'h3, "blink_out");
      push_exp(1'b1, {31'b0, ph}, cyc + 1, "blink_status");
      @(negedge clk);
    end
  endtask

  task automatic wait_empty();
    int budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expected items left, required 0", exp_q.size());
      exp_q.delete();
      due_q.delete();
      kind_q.delete();
      name_q.delete();
    end
  endtask

  task automatic async_reset();
    wait_empty();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_out", 32'(out_port), 32'h0);
    check("async_rst_rd", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    #1;
    check("rst_out", 32'(out_port), 32'h0);
    check("rst_rd", readdata, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // reset / readback
    bus_write(3'd0, 32'h0002_A5A5);
    expect_out(32'h0002_A5A5, "data_out");
    bus_read(3'd0, 32'h0002_A5A5, "data_rd");
    async_reset();
    expect_out(32'h0, "post_rst_out");
    bus_read(3'd0, 32'h0, "post_rst_rd");

    // set / clear
    bus_write(3'd0, 32'h00F0);
    bus_write(3'd4, 32'h000F);
    bus_read(3'd0, 32'h00FF, "outset_rd");
    bus_write(3'd5, 32'h0030);
    bus_read(3'd0, 32'h00CF, "outclr_rd");
    expect_out(32'h00CF, "outclr_out");
    bus_read(3'd4, 32'h0, "rd_outset_0");
    bus_read(3'd5, 32'h0, "rd_outclr_0");

    // PERIOD=0 freezes phase, then PERIOD=4 and PERIOD=1 blink
    bus_write(3'd0, 32'h3);
    bus_write(3'd1, 32'h1);
    bus_read(3'd1, 32'h1, "blink_rd");
    watch_blink(6, 0);
    bus_write(3'd2, 32'd4);
    watch_blink(16, 4);
    bus_write(3'd2, 32'd1);
    watch_blink(6, 1);

    // shrink PERIOD 20 -> 5 while the counter sits at 9 in phase 1
    bus_write(3'd2, 32'd20);
    repeat (29) @(negedge clk);
    expect_out(32'h2, "p20_phase1");
    bus_write(3'd2, 32'd5);
    watch_blink(12, 5);

    // reset mid-blink abandons the count
    bus_write(3'd2, 32'd3);
    repeat (4) @(negedge clk);
    async_reset();
    bus_read(3'd2, 32'h0, "rst_period_rd");
    bus_read(3'd1, 32'h0, "rst_blink_rd");
    bus_read(3'd3, 32'h0, "rst_status_a");
    bus_read(3'd3, 32'h0, "rst_status_b");
    bus_read(3'd3, 32'h0, "rst_status_c");

    // guards
    bus_write(3'd2, 32'hFFFF_FFFF);
    bus_read(3'd2, 32'h00FF_FFFF, "period_width_rd");
    bus_write(3'd2, 32'h0);
    bus_write(3'd0, 32'h155);
    bus_write(3'd1, 32'h0F0);
    address    = 3'd0;
    writedata  = 32'h3FFFF;
    chipselect = 1'b0;
    write_n    = 1'b0;
    @(negedge clk);
    write_n    = 1'b1;
    bus_read(3'd0, 32'h155, "nocs_data");
    bus_write(3'd3, 32'hFFFF);
    bus_write(3'd6, 32'hFFFF);
    bus_write(3'd7, 32'hFFFF);
    bus_read(3'd0, 32'h155, "rsvd_data");
    bus_read(3'd1, 32'h0F0, "rsvd_blink");
    bus_read(3'd2, 32'h0, "rsvd_period");
    bus_read(3'd3, 32'h0, "rsvd_status");
    bus_read(3'd6, 32'h0, "rd_addr6");
    bus_read(3'd7, 32'h0, "rd_addr7");
    bus_write(3'd0, 32'hFFFF_FFFF);
    expect_out(32'h3FFFF, "wide_out");
    bus_read(3'd0, 32'h0003_FFFF, "wide_rd");

    wait_empty();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
